// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the two-requester ALU scheduler: controller states,
// the opcode map understood by the attached ALU, and flag bit positions.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_PASSA = 4'd5;
    localparam logic [3:0] OP_PASSB = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Turns a requester index into its one-hot bit in a 2-bit vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. A lone request always wins; when both requesters
// ask at once, the one that was not served last gets the grant.
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       last,
    output logic [1:0] grant
);

    // Pure combinational grant selection; one-hot or zero.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one registered, fixed-latency ALU between two requesters. One
// operation is in flight at a time; its result and flags are returned to the
// requester that issued it over a valid/ready response channel.
module alu_op_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter int W       = 8,
    parameter int ALU_LAT = 2,
    parameter int NUM_OPS = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [7:0]     req_op,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [3:0]     rsp_flags,
    output logic           rsp_err,
    output logic           busy,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [3:0]     alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic [3:0]     alu_flags
);

    state_t       state;
    state_t       state_next;
    logic [3:0]   cnt;
    logic         owner;
    logic         last;
    logic         err_pending;
    logic [1:0]   grant;
    logic         accept;
    logic         sel;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [3:0]   sel_op;
    logic         op_ok;

    rr_arbiter2 u_arb (
        .req_valid (req_valid),
        .last      (last),
        .grant     (grant)
    );

    // Request-side view: grant is only offered while idle, and the winner's
    // operands are steered out for loading on the accept edge.
    always_comb begin
        req_ready = (state == IDLE) ? grant : 2'b00;
        accept    = |(req_valid & req_ready);
        sel       = grant[1];
        sel_a     = sel ? req_a[2*W-1:W] : req_a[W-1:0];
        sel_b     = sel ? req_b[2*W-1:W] : req_b[W-1:0];
        sel_op    = sel ? req_op[7:4] : req_op[3:0];
        op_ok     = {1'b0, sel_op} < 5'(NUM_OPS);
        busy      = (state != IDLE);
        rsp_valid = (state == RESP) ? onehot2(owner) : 2'b00;
    end

    // Next-state selection; rejected opcodes pass through WAIT with a zero count.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready[owner]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Operand, countdown, ownership and response capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= 4'd0;
            owner       <= 1'b0;
            last        <= 1'b1;
            err_pending <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 4'd0;
            rsp_data    <= '0;
            rsp_flags   <= 4'd0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= sel;
                        if (op_ok) begin
                            alu_a       <= sel_a;
                            alu_b       <= sel_b;
                            alu_op      <= sel_op;
                            cnt         <= 4'(ALU_LAT);
                            err_pending <= 1'b0;
                        end else begin
                            cnt         <= 4'd0;
                            err_pending <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= err_pending ? '0 : alu_result;
                        rsp_flags <= err_pending ? 4'd0 : alu_flags;
                        rsp_err   <= err_pending;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) last <= owner;
                end
                default: begin
                    cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
Shares one registered ALU between two requesters (for example the UART/console path and the switch/button path on the FPGA board). It arbitrates round-robin, issues one operation at a time to the ALU, and waits a fixed parameterised ALU latency. It then captures the result and C/N/V/Z flags and returns them to the requester that owns the operation, using a valid/ready handshake on both the request side and the response side.

Parameters:
W, 8, operand and result width
ALU_LAT, 2, rising edges from alu_a/alu_b/alu_op changing to alu_result/alu_flags being valid (range 1..15)
NUM_OPS, 10, opcodes 0..NUM_OPS-1 are valid; all others are rejected

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
req_valid  in  2  request valid, bit i = requester i
req_ready  out  2  request accepted when req_valid[i] & req_ready[i] on an edge
req_a  in  2*W  operand A; requester i at [i*W +: W]
req_b  in  2*W  operand B; same packing as req_a
req_op  in  8  opcode; requester i at [i*4 +: 4]
rsp_valid  out  2  response valid for requester i
rsp_ready  in  2  response consumed by requester i
rsp_data  out  W  captured ALU result
rsp_flags  out  4  captured flags {C,N,V,Z}
rsp_err  out  1  1 = opcode was rejected
busy  out  1  1 whenever state != IDLE
alu_a  out  W  registered operand A to the ALU
alu_b  out  W  registered operand B to the ALU
alu_op  out  4  registered opcode to the ALU
alu_result  in  W  ALU result
alu_flags  in  4  ALU flags {C,N,V,Z}

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE.
  - All outputs are 0, including the alu_* registers and the rsp_* registers.
  - The round-robin pointer favours requester 0.
  - Any operation in flight is dropped with no response.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational and one-hot: it goes to the single requester chosen by the arbiter among those asserting req_valid.
  - If both requesters are valid, the one not served last wins. If only one is valid, it wins regardless of the pointer.
  - With no valid request, req_ready=0.
- Accept edge, valid opcode:
  - alu_a, alu_b and alu_op load the owner's operands and opcode.
  - The owner index is latched.
  - cnt loads ALU_LAT and the state goes to WAIT.
- Accept edge, req_op >= NUM_OPS:
  - The alu_* registers are unchanged.
  - On the next edge the state goes to RESP with rsp_err=1, rsp_data=0 and rsp_flags=0.
- WAIT:
  - cnt decrements each edge.
  - On the edge where cnt==0, alu_result and alu_flags are captured into rsp_data and rsp_flags, rsp_err=0, and the state goes to RESP.
  - rsp_valid[owner] is therefore first visible after edge e0+ALU_LAT+1, where e0 is the accept edge.
- alu_* hold stable from the accept edge until the next accept. They are never changed in WAIT or RESP.
- RESP:
  - rsp_valid[owner]=1; the other bit is 0.
  - rsp_data, rsp_flags and rsp_err hold stable until rsp_ready[owner]=1 on an edge.
  - On that edge: rsp_valid clears, the pointer updates to the served requester, and the state goes to IDLE.
  - rsp_ready of the non-owner is ignored.
- Throughput: at most one operation per ALU_LAT+3 cycles (no accept is possible in the IDLE-return cycle's preceding RESP).
- req_ready=0 in WAIT and RESP. A requester may drop req_valid before acceptance; nothing is latched.
- The flags are passed through unmodified; the scheduler performs no arithmetic.

Decomposition:
- Package alu_ctrl_pkg:
  - state enum {IDLE, WAIT, RESP}
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3 (remaining up to NUM_OPS-1 as the ALU defines)
  - flag index constants FLAG_C=3, FLAG_N=2, FLAG_V=1, FLAG_Z=0
- Sub-module rr_arbiter2: combinational 2-way grant from req_valid and the last-served pointer. The pointer register stays in the top.

Test Plan:
- Single add (W=8, ALU_LAT=2, ALU behavioural model): req0 a=1A, b=2B, op=0, rsp_ready=1 -> rsp_valid=01 exactly 3 edges after accept, rsp_data=45, rsp_flags=0000, rsp_err=0.
- Contention after reset: both valid; req0 SUB 3C,1F; req1 AND FF,0F -> req0 served first with data=1D, then req1 with data=0F. With valid held continuously, service strictly alternates 0,1,0,1.
- Backpressure: rsp_ready=00 for 5 cycles in RESP -> rsp_data, rsp_flags and rsp_valid stable; req_ready=00; busy=1. The next accept occurs only after the rsp_ready[owner] edge plus one IDLE cycle.
- Invalid opcode: req1 op=F -> rsp_valid=10 one edge after accept, rsp_err=1, data=00, flags=0000, alu_* unchanged.
- Reset in WAIT: reset=0 mid-count -> all outputs 0 immediately, no response after release, and a subsequent req0 ADD 01+01 returns 02 normally.
- Flag capture: SUB 00-01 with the model producing FF, N=1, C=1 -> rsp_data=FF, rsp_flags=1100.
